// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 program loader: width defaults and FSM state codes.
`timescale 1ns/1ps
package td4_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_FILL = 2'd2;
  localparam state_t ST_RUN  = 2'd3;

  // IDLE and LOAD are the only states that take words from the load stream.
  function automatic logic accepts_words(input state_t s);
    return (s == ST_IDLE) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store for the TD4 CPU: synchronous write port, asynchronous read port.
`timescale 1ns/1ps
module prog_mem
  import td4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset on purpose; a reset must leave the last program intact.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Streams a program into prog_mem, zero-fills the unused tail, then releases the CPU.
`timescale 1ns/1ps
module prog_loader
  import td4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_n_reset,
  output logic [ADDR_W:0]   prog_len,
  output logic              running
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] wptr;
  logic              beat;
  logic              fill_cyc;
  logic              wptr_last;
  logic              do_reload;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign ld_ready  = accepts_words(state);
  assign beat      = ld_valid & ld_ready;
  assign fill_cyc  = (state == ST_FILL);
  assign wptr_last = (wptr == {ADDR_W{1'b1}});
  assign do_reload = (state == ST_RUN) & reload;

  // NOTE: every branch starts from next_state = state, so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (beat) begin
          if (wptr_last)    next_state = ST_RUN;
          else if (ld_last) next_state = ST_FILL;
          else              next_state = ST_LOAD;
        end
      end
      ST_FILL: if (wptr_last) next_state = ST_RUN;
      ST_RUN:  if (reload)    next_state = ST_IDLE;
      default:                next_state = ST_IDLE;
    endcase
  end

  // NOTE: all state here updates with <= so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      wptr        <= '0;
      prog_len    <= '0;
      cpu_n_reset <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= next_state;
      // Both flags follow the next state so they are high exactly while state is RUN.
      cpu_n_reset <= (next_state == ST_RUN);
      running     <= (next_state == ST_RUN);
      if (do_reload) begin
        wptr     <= '0;
        prog_len <= '0;
      end else begin
        if (beat || fill_cyc) wptr     <= wptr + 1'b1;
        if (beat)             prog_len <= prog_len + 1'b1;
      end
    end
  end

  // Reset blocks writes so an abandoned sequence cannot touch memory on the reset edge.
  assign mem_we    = ~reset & (beat | fill_cyc);
  assign mem_wdata = beat ? ld_data : '0;

  prog_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wptr),
    .wdata(mem_wdata),
    .raddr(address),
    .rdata(mem_rdata)
  );

  assign instr = (state == ST_RUN) ? mem_rdata : '0;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed loads, fill, reload, reset and a TD4 program run.
`timescale 1ns/1ps
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       reload;
  logic [3:0] address;
  logic [7:0] instr;
  logic       cpu_n_reset;
  logic [4:0] prog_len;
  logic       running;

  prog_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .reload     (reload),
    .address    (address),
    .instr      (instr),
    .cpu_n_reset(cpu_n_reset),
    .prog_len   (prog_len),
    .running    (running)
  );

  always #5 clk = ~clk;

  typedef enum {K_INSTR, K_LEN, K_NRST, K_RUN, K_RDY} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } sb_t;
  typedef logic [7:0] img_t [16];
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] o;
    logic [3:0] pc;
    logic       c;
  } td4_t;

  sb_t  sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  img_t pat   = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                  8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h87};
  img_t ramen = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                  8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
  img_t short3 = '{8'hB7, 8'h01, 8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  img_t short2 = '{8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  localparam int CPU_STEPS = 200;
  logic [3:0] out_rom [CPU_STEPS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_val(input kind_e k, input logic [31:0] exp, input string name);
    sb.push_back('{kind: k, exp: exp, name: name});
  endtask

  // Monitor: drains expectations against the DUT outputs on every falling edge.
  initial begin : monitor
    sb_t         e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_INSTR: act = 32'(instr);
          K_LEN:   act = 32'(prog_len);
          K_NRST:  act = 32'(cpu_n_reset);
          K_RUN:   act = 32'(running);
          default: act = 32'(ld_ready);
        endcase
        check(e.name, act, e.exp);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int budget = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    while (!ld_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!ld_ready) check("send_ready_timeout", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic status(input string tag, input int len, input bit run, input bit nrst, input bit rdy);
    expect_val(K_LEN,  32'(len),  {tag, "_prog_len"});
    expect_val(K_RUN,  32'(run),  {tag, "_running"});
    expect_val(K_NRST, 32'(nrst), {tag, "_cpu_n_reset"});
    expect_val(K_RDY,  32'(rdy),  {tag, "_ld_ready"});
  endtask

  task automatic check_mem(input img_t img, input string tag);
    for (int i = 0; i < 16; i++) begin
      address = 4'(i);
      expect_val(K_INSTR, 32'(img[i]), $sformatf("%s_instr%0d", tag, i));
      tick();
    end
  endtask

  task automatic wait_run(input string tag, input int budget);
    int k = 0;
    while (!running && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_reach_run"}, 32'(running), 32'd1);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  function automatic td4_t td4_step(input logic [7:0] ins, input logic [3:0] in_p, input td4_t s);
    td4_t       n;
    logic [4:0] sum;
    logic [3:0] im;
    n    = s;
    im   = ins[3:0];
    n.c  = 1'b0;
    n.pc = s.pc + 4'd1;
    case (ins[7:4])
      4'b0000: begin sum = {1'b0, s.a} + {1'b0, im}; n.a = sum[3:0]; n.c = sum[4]; end
      4'b0001: begin sum = {1'b0, s.b} + {1'b0, im}; n.a = sum[3:0]; n.c = sum[4]; end
      4'b0010: begin sum = {1'b0, in_p} + {1'b0, im}; n.a = sum[3:0]; n.c = sum[4]; end
      4'b0011: n.a = im;
      4'b0100: begin sum = {1'b0, s.a} + {1'b0, im}; n.b = sum[3:0]; n.c = sum[4]; end
      4'b0101: begin sum = {1'b0, s.b} + {1'b0, im}; n.b = sum[3:0]; n.c = sum[4]; end
      4'b0110: begin sum = {1'b0, in_p} + {1'b0, im}; n.b = sum[3:0]; n.c = sum[4]; end
      4'b0111: n.b = im;
      4'b1001: n.o = s.b;
      4'b1011: n.o = im;
      4'b1110: if (!s.c) n.pc = im;
      4'b1111: n.pc = im;
      default: ;
    endcase
    return n;
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    td4_t       st;
    logic [7:0] ins;
    int         ndiff;

    // Reference trace from the program as a fixed ROM.
    st = '0;
    for (int s = 0; s < CPU_STEPS; s++) begin
      st = td4_step(ramen[st.pc], 4'b0101, st);
      out_rom[s] = st.o;
    end

    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; reload = 1'b0; address = '0;
    tick(2);
    reset = 1'b0;
    status("reset", 0, 0, 0, 1);
    expect_val(K_INSTR, 32'h00, "reset_instr");
    tick();

    // Gapped 16-word load: one valid in three cycles.
    for (int i = 0; i < 16; i++) begin
      send(pat[i], i == 15);
      if (i == 4) expect_val(K_LEN, 32'd5, "gap_len_after5");
      if (i < 15) tick(2);
    end
    status("gap_done", 16, 1, 1, 0);
    check_mem(pat, "gap");

    // ld_valid in RUN is ignored; then reload together with ld_valid.
    address  = 4'd0;
    ld_valid = 1'b1;
    ld_data  = 8'hAA;
    tick(2);
    expect_val(K_LEN, 32'd16, "run_valid_len");
    expect_val(K_RUN, 32'd1, "run_valid_running");
    expect_val(K_INSTR, 32'h12, "run_valid_instr0");
    reload = 1'b1;
    tick();
    reload   = 1'b0;
    ld_valid = 1'b0;
    status("reload", 0, 0, 0, 1);
    expect_val(K_INSTR, 32'h00, "reload_instr");
    tick();

    // Short program: 3 words then 13 fill cycles.
    send(8'hB7, 1'b0);
    send(8'h01, 1'b0);
    send(8'hE1, 1'b1);
    status("fill_start", 3, 0, 0, 0);
    tick(12);
    expect_val(K_RUN, 32'd0, "fill12_running");
    expect_val(K_NRST, 32'd0, "fill12_cpu_n_reset");
    tick();
    status("fill_done", 3, 1, 1, 0);
    check_mem(short3, "short3");

    // Reset in the middle of a load, then a 2-word load.
    do_reload();
    for (int i = 0; i < 5; i++) send(8'hA1 + 8'(i), 1'b0);
    expect_val(K_LEN, 32'd5, "pre_reset_len");
    tick();
    reset    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'h55;
    tick();
    reset    = 1'b0;
    ld_valid = 1'b0;
    status("mid_reset", 0, 0, 0, 1);
    tick();
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b1);
    wait_run("two_word", 20);
    status("two_word", 2, 1, 1, 0);
    check_mem(short2, "two_word");

    // Full ramen-timer program, back to back.
    do_reload();
    for (int i = 0; i < 16; i++) send(ramen[i], i == 15);
    status("ramen", 16, 1, 1, 0);
    check_mem(ramen, "ramen");

    // CPU fetching from the loader must reproduce the ROM-based output trace.
    st    = '0;
    ndiff = 0;
    for (int s = 0; s < CPU_STEPS; s++) begin
      address = st.pc;
      expect_val(K_INSTR, 32'(ramen[st.pc]), $sformatf("cpu_fetch%0d", s));
      @(negedge clk);
      ins = instr;
      st  = td4_step(ins, 4'b0101, st);
      if (st.o !== out_rom[s]) ndiff++;
      tick();
    end
    check("cpu_out_trace_diffs", 32'(ndiff), 32'd0);
    check("cpu_final_out", 32'(st.o), 32'(out_rom[CPU_STEPS-1]));

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 Parameter DATA_W SHALL default to 8 and set the instruction word width.
REQ-003 Parameter ADDR_W SHALL default to 4 and set the address width; depth is 2**ADDR_W (16).
REQ-004 Port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-005 Port reset SHALL be: input, 1 bit, synchronous active-high reset.
REQ-006 Port ld_valid SHALL be: input, 1 bit, load word present.
REQ-007 Port ld_ready SHALL be: output, 1 bit, loader accepts a word this cycle.
REQ-008 Port ld_data SHALL be: input, DATA_W bits, instruction word to store.
REQ-009 Port ld_last SHALL be: input, 1 bit, qualifies the final word of a program.
REQ-010 Port reload SHALL be: input, 1 bit, request to re-enter load mode from RUN.
REQ-011 Port address SHALL be: input, ADDR_W bits, CPU program counter.
REQ-012 Port instr SHALL be: output, DATA_W bits, instruction at address.
REQ-013 Port cpu_n_reset SHALL be: output, 1 bit, active-low reset to the CPU.
REQ-014 Port prog_len SHALL be: output, ADDR_W+1 bits, words loaded (0..16).
REQ-015 Port running SHALL be: output, 1 bit, high in RUN.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, FILL, RUN.
REQ-017 A beat SHALL be ld_valid & ld_ready; ld_ready SHALL be high only in IDLE and LOAD.
REQ-018 Each beat SHALL write ld_data to mem[wptr] at the clock edge, then increment wptr and prog_len.
REQ-019 Transitions: IDLE to LOAD on a beat without ld_last; IDLE/LOAD to RUN on a beat with ld_last at wptr=15, or on any beat at wptr=15.
REQ-020 IDLE/LOAD to FILL on a beat with ld_last at wptr<15.
REQ-021 FILL SHALL write 8'h00 to mem[wptr] once per cycle, with wptr incrementing; after the write at wptr=15, wptr wraps to 0 and the FSM enters RUN.
REQ-022 prog_len SHALL NOT count FILL writes.
REQ-023 RUN to IDLE on reload; wptr and prog_len SHALL clear to 0 on that transition.
REQ-024 reload SHALL be ignored outside RUN.
REQ-025 reload and ld_valid in the same RUN cycle: reload wins, and no beat is accepted.
REQ-026 instr SHALL be a combinational read of mem[address] (zero latency) in RUN, and 8'h00 in every other state.
REQ-027 cpu_n_reset SHALL be registered: low in IDLE/LOAD/FILL and high from the first RUN cycle, giving the CPU a falling edge on every load.
REQ-028 running SHALL equal (state==RUN) and be registered.
REQ-029 ld_valid held with ld_ready low SHALL cause no write and no state change.

Reset
REQ-030 On reset: state=IDLE, wptr=0, prog_len=0, cpu_n_reset=0, running=0, ld_ready=1 from the next cycle.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 Reset during LOAD or FILL SHALL abandon the sequence; the partial contents are retained but unusable until a full load completes.
REQ-033 Reset SHALL take priority over every other input.

Structure
REQ-034 The state encoding and the DATA_W/ADDR_W defaults SHALL live in a shared package, td4_pkg.
REQ-035 The memory SHALL be one sub-module, prog_mem: 16x8 with synchronous write and asynchronous read.
REQ-036 The FSM, wptr and prog_len SHALL live in prog_loader.

Verification
REQ-037 Load the 16-word ramen-timer program with ld_last on word 16 -> RUN after the 16th beat, prog_len=16, and instr matches for all 16 addresses.
REQ-038 Load 3 words {B7,01,E1} with ld_last on the third -> 13 FILL cycles, then RUN, prog_len=3, mem[3..15]=00, and cpu_n_reset rises on the first RUN cycle.
REQ-039 Toggle ld_valid with gaps (1 valid in 3 cycles) -> words stored in order, and no duplicates.
REQ-040 Assert reset after 5 beats -> IDLE, prog_len=0, cpu_n_reset=0; a following 2-word load leaves prog_len=2.
REQ-041 In RUN, pulse reload together with ld_valid -> IDLE, no write, prog_len=0, instr=00, and cpu_n_reset low the next cycle.
REQ-042 Connect a CPU to this block and run the timer program with in=0101 -> out sequence identical to the ROM-based run.
